pack_to_1bit: RTL and testbench
===============================

PACK_TO_1BIT -- requirements
Module: pack_to_1bit

Interface
REQ-001 SHALL have parameter THRESH, default 0, signed 8-bit threshold; an input byte packs to 1 when its signed value > THRESH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous abort of the word being assembled.
REQ-005 SHALL have port in_valid  input  1  data_in carries a beat.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port data_in  input  1024  128 signed bytes; byte i = data_in[i*8 +: 8].
REQ-008 SHALL have port addr  output  3  chunk slot the next accepted beat fills.
REQ-009 SHALL have port out_valid  output  1  data_out holds a complete packed word.
REQ-010 SHALL have port out_ready  input  1  consumer takes data_out this cycle.
REQ-011 SHALL have port data_out  output  1024  32 x 32-bit packed word; chunk k = data_out[k*128 +: 128].

Function
REQ-012 SHALL implement states FILL and FULL; reset state FILL.
REQ-013 SHALL drive in_ready = 1 in FILL, 0 in FULL (registered-state decode, no dependence on in_valid).
REQ-014 SHALL accept a beat when in_valid && in_ready; bit i of chunk addr = (signed data_in[i*8 +: 8] > THRESH), written into data_out[addr*128 + i] at that edge.
REQ-015 SHALL increment addr by 1 on each acceptance; acceptance at addr = 7 wraps addr to 0 and moves state to FULL.
REQ-016 SHALL assert out_valid exactly when state is FULL, i.e. the cycle after the 8th acceptance (latency 1).
REQ-017 SHALL, in FULL with out_ready = 1, return to FILL next cycle; in_ready rises that cycle.
REQ-018 SHALL hold data_out and out_valid stable while FULL and out_ready = 0.
REQ-019 SHALL not clear data_out on handshake; chunks are overwritten as new beats are accepted.
REQ-020 SHALL ignore in_valid while FULL (no write, no addr change).
REQ-021 SHALL, on clear = 1, set addr to 0, state to FILL, out_valid to 0 next cycle; data_out unchanged; clear overrides a simultaneous accept or output handshake.
REQ-022 SHALL ignore out_ready while in FILL.

Reset
REQ-023 SHALL, while rst = 1 at a clk edge, set state FILL, addr 0, data_out all zeros, out_valid 0; rst has priority over clear and all handshakes.
REQ-024 SHALL drive in_ready = 1 in the first cycle after rst deasserts.
REQ-025 SHALL discard any partially assembled word when rst asserts mid-fill.

Structure
REQ-026 SHALL place shared constants (CHUNK_BITS = 128, NUM_CHUNKS = 8, BYTE_W = 8, WORD_BITS = 1024) in the shared TPU constants include, common with expand_to_8bit.
REQ-027 SHALL use one sub-module, byte_threshold (128 parallel signed compares, 1024-bit in -> 128-bit out), combinational.
REQ-028 SHALL keep bit order exactly inverse of expand_to_8bit: chunk addr, bit i <-> byte i.

Verification
REQ-029 SHALL cover: rst, then 8 beats with every byte 8'h7F, out_ready = 1 -> out_valid high one cycle after beat 8, data_out = all ones, in_ready high next cycle.
REQ-030 SHALL cover: beats alternating bytes {8'h01, 8'hFF} (byte 0 = 8'h01), THRESH = 0 -> every chunk = {64{2'b01}}.
REQ-031 SHALL cover: FULL with out_ready = 0 for 5 cycles while in_valid = 1 -> data_out, addr = 0 unchanged, in_ready = 0 throughout.
REQ-032 SHALL cover: clear after 3 beats, then 8 fresh beats of 8'h80 -> out_valid only after the 8 fresh beats; data_out = all zeros.
REQ-033 SHALL cover: rst asserted with addr = 5 and simultaneous in_valid -> next cycle addr = 0, data_out = 0, out_valid = 0.
REQ-034 SHALL cover: round trip, data_out fed to expand_to_8bit for addr 0..7 and re-packed -> identical 1024-bit word.

Source files
------------

// File: rtl/pack_to_1bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pack_to_1bit_pkg
// Description : Shared TPU packing constants (common with expand_to_8bit)
//               and the state encoding of the 1-bit packer.
//               No ports; imported by pack_to_1bit and byte_threshold.
// Revision    : 1.0  initial release
// ============================================================================
package pack_to_1bit_pkg;

   localparam int CHUNK_BITS = 128;   // bits produced per accepted beat
   localparam int NUM_CHUNKS = 8;     // beats per packed word
   localparam int BYTE_W     = 8;     // width of one signed input element
   localparam int WORD_BITS  = 1024;  // packed word width
   localparam int ADDR_W     = 3;     // chunk slot index width

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_threshold.sv
`default_nettype none
// ============================================================================
// Module      : byte_threshold
// Description : 128 parallel signed compares; bit i = (signed byte i > THRESH).
//               Purely combinational.
// Ports       : bytes_in  [1023:0]  128 signed bytes, byte i = bytes_in[i*8 +: 8]
//               bits_out  [127:0]   one compare result per byte
// Revision    : 1.0  initial release
// ============================================================================
module byte_threshold
   import pack_to_1bit_pkg::*;
#(
   parameter logic signed [7:0] THRESH = 8'sd0
) (
   input  logic [WORD_BITS-1:0]  bytes_in,
   output logic [CHUNK_BITS-1:0] bits_out
);

   for (genvar i = 0; i < CHUNK_BITS; i++) begin : g_byte
      assign bits_out[i] = $signed(bytes_in[i*BYTE_W +: BYTE_W]) > THRESH;
   end

endmodule
`default_nettype wire

// File: rtl/pack_to_1bit.sv
`default_nettype none
// ============================================================================
// Module      : pack_to_1bit
// Description : Thresholds 8 beats of 128 signed bytes into one 1024-bit word
//               (chunk addr, bit i <-> byte i of that beat) and presents it
//               with a valid/ready handshake.
// Ports       : clk, rst        clock, synchronous active-high reset
//               clear           synchronous abort of the word being assembled
//               in_valid/in_ready/data_in [1023:0]   input beat handshake
//               addr [2:0]      chunk slot the next accepted beat fills
//               out_valid/out_ready/data_out [1023:0] packed word handshake
// Revision    : 1.0  initial release
// ============================================================================
module pack_to_1bit
   import pack_to_1bit_pkg::*;
#(
   parameter logic signed [7:0] THRESH = 8'sd0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_BITS-1:0] data_in,
   output logic [ADDR_W-1:0]    addr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_BITS-1:0] data_out
);

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q,  addr_d;
   logic [WORD_BITS-1:0]   data_q,  data_d;
   logic [CHUNK_BITS-1:0]  chunk_bits;

   byte_threshold #(
      .THRESH (THRESH)
   ) u_byte_threshold (
      .bytes_in (data_in),
      .bits_out (chunk_bits)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (clear) begin
         // Abort wins over accept and output handshake; the word is left intact.
         state_d = ST_FILL;
         addr_d  = '0;
      end else if (state_q == ST_FILL) begin
         if (in_valid) begin
            data_d[{addr_q, 7'd0} +: CHUNK_BITS] = chunk_bits;
            addr_d = addr_q + 3'd1;       // wraps 7 -> 0
            if (addr_q == 3'(NUM_CHUNKS - 1)) begin
               state_d = ST_FULL;
            end
         end
      end else begin
         if (out_ready) begin
            state_d = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = (state_q == ST_FILL);
   assign out_valid = (state_q == ST_FULL);
   assign addr      = addr_q;
   assign data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_pack_to_1bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pack_to_1bit
// Description : Directed self-checking bench for pack_to_1bit (THRESH = 0).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pack_to_1bit;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1023:0] data_in = '0;
   logic [2:0]    addr;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1023:0] data_out;

   int checks = 0;
   int errors = 0;

   pack_to_1bit #(.THRESH(8'sd0)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .addr      (addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1023:0] fill_bytes(input logic [7:0] b);
      logic [1023:0] w;
      for (int i = 0; i < 128; i++) w[i*8 +: 8] = b;
      return w;
   endfunction

   // Reference threshold for THRESH = 0: strictly positive signed bytes map to 1.
   function automatic logic [127:0] ref_pack(input logic [1023:0] d);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = (d[i*8+7] == 1'b0) && (d[i*8 +: 8] != 8'h00);
      return r;
   endfunction

   task automatic send_beats(input logic [1023:0] d, input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         data_in  = d;
         step();
      end
      in_valid = 1'b0;
   endtask

   logic [1023:0] alt_beat, exp_word, held, beats [8];
   logic [1023:0] ones, alt_word;

   initial begin
      ones = '1;
      for (int i = 0; i < 128; i++) alt_beat[i*8 +: 8] = (i % 2 == 0) ? 8'h01 : 8'hFF;
      alt_word = {16{64'h5555_5555_5555_5555}};

      // Reset state
      step(); step();
      chk("rst_data", data_out, '0);
      rst = 1'b0;
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_addr", addr, 0);

      // All 8'h7F, out_ready held high (ignored in FILL)
      out_ready = 1'b1;
      send_beats(fill_bytes(8'h7F), 7);
      chk("t1_valid_after7", out_valid, 0);
      chk("t1_addr_after7", addr, 7);
      send_beats(fill_bytes(8'h7F), 1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_data_ones", data_out, ones);
      chk("t1_in_ready_low", in_ready, 0);
      chk("t1_addr_wrap", addr, 0);
      step();
      chk("t1_in_ready_back", in_ready, 1);
      chk("t1_valid_drop", out_valid, 0);
      chk("t1_data_kept", data_out, ones);

      // Alternating {01, FF}: every chunk = {64{2'b01}}
      out_ready = 1'b0;
      send_beats(alt_beat, 8);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_alt", data_out, alt_word);

      // Stall in FULL with in_valid asserted
      in_valid = 1'b1;
      data_in  = fill_bytes(8'h7F);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t3_hold_data", data_out, alt_word);
         chk("t3_hold_addr", addr, 0);
         chk("t3_hold_in_ready", in_ready, 0);
         chk("t3_hold_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_release", out_valid, 0);
      chk("t3_no_clear", data_out, alt_word);

      // Clear after 3 beats, then 8 fresh beats of 8'h80
      send_beats(fill_bytes(8'h7F), 3);
      chk("t4_addr3", addr, 3);
      exp_word = {alt_word[1023:384], 384'h0} | {640'h0, {384{1'b1}}};
      chk("t4_partial", data_out, exp_word);
      clear    = 1'b1;
      in_valid = 1'b1;
      data_in  = fill_bytes(8'h00);
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t4_clear_addr", addr, 0);
      chk("t4_clear_data", data_out, exp_word);
      chk("t4_clear_ready", in_ready, 1);
      send_beats(fill_bytes(8'h80), 7);
      chk("t4_valid_early", out_valid, 0);
      send_beats(fill_bytes(8'h80), 1);
      chk("t4_valid", out_valid, 1);
      chk("t4_zeros", data_out, '0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // rst mid-fill at addr 5 with in_valid
      send_beats(fill_bytes(8'h7F), 5);
      chk("t5_addr5", addr, 5);
      rst      = 1'b1;
      in_valid = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("t5_addr", addr, 0);
      chk("t5_data", data_out, '0);
      chk("t5_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 1);

      // Threshold boundary bytes: 00, 01, 7F, 80, FF -> 0,1,1,0,0
      begin
         logic [1023:0] b;
         b = fill_bytes(8'h00);
         b[7:0] = 8'h00; b[15:8] = 8'h01; b[23:16] = 8'h7F; b[31:24] = 8'h80; b[39:32] = 8'hFF;
         send_beats(b, 8);
         exp_word = {8{128'h2}} | {8{128'h4}};
         chk("t6_boundary", data_out, exp_word);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end

      // Random beats, then round trip through a 1-bit -> byte expansion
      for (int k = 0; k < 8; k++) begin
         for (int w = 0; w < 32; w++) beats[k][w*32 +: 32] = $urandom;
         exp_word[k*128 +: 128] = ref_pack(beats[k]);
      end
      for (int k = 0; k < 8; k++) send_beats(beats[k], 1);
      chk("t7_random", data_out, exp_word);
      held = data_out;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic [1023:0] e;
         for (int i = 0; i < 128; i++) e[i*8 +: 8] = held[k*128 + i] ? 8'h01 : 8'h00;
         send_beats(e, 1);
      end
      chk("t7_round_trip", data_out, held);
      chk("t7_rt_valid", out_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
